// File: rtl/uc_pkg.sv
// Shared definitions for the accumulator-core control unit: opcodes,
// FSM state encoding and default widths.
package uc_pkg;

  localparam int ADR_W  = 6;
  localparam int DATA_W = ADR_W + 2;

  localparam logic [1:0] OP_NOR = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_STA = 2'b10;
  localparam logic [1:0] OP_JCC = 2'b11;

  typedef enum logic [3:0] {
    S_INIT    = 4'd0,
    S_FETCH   = 4'd1,
    S_LOAD_IR = 4'd2,
    S_DECODE  = 4'd3,
    S_READ_OP = 4'd4,
    S_EXEC    = 4'd5,
    S_STORE   = 4'd6,
    S_JUMP    = 4'd7
  } state_t;

endpackage

// File: rtl/uc_sequencer_instr_reg.sv
// Instruction register: captures a fetched word when loaded with ce high and
// splits it into the opcode (two MSBs) and the address field.
module instr_reg #(
  parameter int ADR_W  = uc_pkg::ADR_W,
  parameter int DATA_W = uc_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [1:0]        ir_op,
  output logic [ADR_W-1:0]  ir_adr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_op  <= 2'b00;
      ir_adr <= '0;
    end else if (ce && load) begin
      ir_op  <= d[DATA_W-1 -: 2];
      ir_adr <= d[ADR_W-1:0];
    end
  end

endmodule

// File: rtl/uc_sequencer.sv
// Fetch/decode/execute sequencer for the NOR/ADD/STA/JCC accumulator core.
// Strobes are decoded from the current state and gated by ce.
module uc_sequencer #(
  parameter int ADR_W  = uc_pkg::ADR_W,
  parameter int DATA_W = uc_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [DATA_W-1:0] data_in,
  input  logic              carry_in,
  output logic              clear_PC,
  output logic              load_PC,
  output logic              enable_PC,
  output logic [1:0]        ir_op,
  output logic [ADR_W-1:0]  ir_adr,
  output logic              sel_adr,
  output logic              ce_mem,
  output logic              we_mem,
  output logic              load_ACCU,
  output logic [1:0]        sel_op,
  output logic              load_carry,
  output logic              init_carry
);
  import uc_pkg::*;

  state_t state;
  logic   ir_load;

  assign ir_load = (state == S_LOAD_IR);

  instr_reg #(.ADR_W(ADR_W), .DATA_W(DATA_W)) u_ir (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .load   (ir_load),
    .d      (data_in),
    .ir_op  (ir_op),
    .ir_adr (ir_adr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_INIT;
    end else if (ce) begin
      case (state)
        S_INIT:    state <= S_FETCH;
        S_FETCH:   state <= S_LOAD_IR;
        S_LOAD_IR: state <= S_DECODE;
        S_DECODE: begin
          case (ir_op)
            OP_NOR, OP_ADD: state <= S_READ_OP;
            OP_STA:         state <= S_STORE;
            default:        state <= S_JUMP;
          endcase
        end
        S_READ_OP: state <= S_EXEC;
        S_EXEC:    state <= S_FETCH;
        S_STORE:   state <= S_FETCH;
        S_JUMP:    state <= S_FETCH;
        default:   state <= S_INIT;
      endcase
    end
  end

  // JCC jumps only when carry is clear; the carry is cleared either way.
  always_comb begin
    clear_PC   = 1'b0;
    load_PC    = 1'b0;
    enable_PC  = 1'b0;
    sel_adr    = 1'b0;
    ce_mem     = 1'b0;
    we_mem     = 1'b0;
    load_ACCU  = 1'b0;
    load_carry = 1'b0;
    init_carry = 1'b0;
    if (ce) begin
      case (state)
        S_INIT: begin
          clear_PC   = 1'b1;
          enable_PC  = 1'b1;
          init_carry = 1'b1;
        end
        S_FETCH:   ce_mem = 1'b1;
        S_LOAD_IR: enable_PC = 1'b1;
        S_READ_OP: begin
          ce_mem  = 1'b1;
          sel_adr = 1'b1;
        end
        S_EXEC: begin
          load_ACCU  = 1'b1;
          load_carry = (ir_op == OP_ADD);
        end
        S_STORE: begin
          ce_mem  = 1'b1;
          we_mem  = 1'b1;
          sel_adr = 1'b1;
        end
        S_JUMP: begin
          load_PC    = ~carry_in;
          init_carry = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sel_op = ir_op;

endmodule

// File: tb/tb_uc_sequencer.sv
// Scoreboard bench for uc_sequencer: each instruction pushes its expected
// per-cycle output vectors, which are popped and compared cycle by cycle.
module tb_uc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [7:0] data_in;
  logic       carry_in;
  logic       clear_PC, load_PC, enable_PC, sel_adr, ce_mem, we_mem;
  logic       load_ACCU, load_carry, init_carry;
  logic [1:0] ir_op, sel_op;
  logic [5:0] ir_adr;

  int testsRun = 0;
  int testsFailed = 0;

  // Strobe order: clear, load, enable, sel_adr, ce_mem, we_mem, load_ACCU, load_carry, init_carry
  localparam logic [8:0] S_INIT_V  = 9'b101000001;
  localparam logic [8:0] S_FETCH_V = 9'b000010000;
  localparam logic [8:0] S_LDIR_V  = 9'b001000000;
  localparam logic [8:0] S_NONE_V  = 9'b000000000;
  localparam logic [8:0] S_RDOP_V  = 9'b000110000;
  localparam logic [8:0] S_EXADD_V = 9'b000000110;
  localparam logic [8:0] S_EXNOR_V = 9'b000000100;
  localparam logic [8:0] S_STORE_V = 9'b000111000;
  localparam logic [8:0] S_JMP0_V  = 9'b010000001;
  localparam logic [8:0] S_JMP1_V  = 9'b000000001;

  typedef struct {
    logic        ce;
    logic        carry;
    logic [7:0]  data;
    logic [18:0] exp;
    string       tag;
  } entry_t;

  entry_t sb[$];
  logic [1:0] curOp;
  logic [5:0] curAdr;

  wire [18:0] actual = {clear_PC, load_PC, enable_PC, sel_adr, ce_mem, we_mem,
                        load_ACCU, load_carry, init_carry, ir_op, ir_adr, sel_op};

  uc_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .data_in    (data_in),
    .carry_in   (carry_in),
    .clear_PC   (clear_PC),
    .load_PC    (load_PC),
    .enable_PC  (enable_PC),
    .ir_op      (ir_op),
    .ir_adr     (ir_adr),
    .sel_adr    (sel_adr),
    .ce_mem     (ce_mem),
    .we_mem     (we_mem),
    .load_ACCU  (load_ACCU),
    .sel_op     (sel_op),
    .load_carry (load_carry),
    .init_carry (init_carry)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] ev(logic [8:0] s, logic [1:0] op, logic [5:0] adr);
    return {s, op, adr, op};
  endfunction

  task automatic checkOutput(input string tag, input logic [18:0] act, input logic [18:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  task automatic pushEntry(input logic c, input logic cy, input logic [7:0] d,
                           input logic [18:0] e, input string tag);
    entry_t x;
    x.ce = c; x.carry = cy; x.data = d; x.exp = e; x.tag = tag;
    sb.push_back(x);
  endtask

  // Push the expected cycle sequence of one instruction, starting at FETCH.
  task automatic applyStimulus(input logic [7:0] instr, input logic cy, input int stall);
    logic [1:0] op;
    logic [5:0] adr;
    op  = instr[7:6];
    adr = instr[5:0];
    pushEntry(1'b1, cy, instr, ev(S_FETCH_V, curOp, curAdr), "fetch");
    pushEntry(1'b1, cy, instr, ev(S_LDIR_V, curOp, curAdr), "load_ir");
    pushEntry(1'b1, cy, instr, ev(S_NONE_V, op, adr), "decode");
    case (op)
      2'b00, 2'b01: begin
        for (int i = 0; i < stall; i++)
          pushEntry(1'b0, cy, instr, ev(S_NONE_V, op, adr), "stall");
        pushEntry(1'b1, cy, instr, ev(S_RDOP_V, op, adr), "read_op");
        pushEntry(1'b1, cy, instr, ev(op == 2'b01 ? S_EXADD_V : S_EXNOR_V, op, adr), "exec");
      end
      2'b10: pushEntry(1'b1, cy, instr, ev(S_STORE_V, op, adr), "store");
      default: pushEntry(1'b1, cy, instr, ev(cy ? S_JMP1_V : S_JMP0_V, op, adr), "jump");
    endcase
    curOp  = op;
    curAdr = adr;
  endtask

  task automatic drainQueue();
    entry_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      @(posedge clk);
      #1;
      ce       = x.ce;
      carry_in = x.carry;
      data_in  = x.data;
      @(negedge clk);
      #1;
      checkOutput(x.tag, actual, x.exp);
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; data_in = 8'h00; carry_in = 1'b0;
    curOp = 2'b00; curAdr = 6'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset", actual, ev(S_NONE_V, 2'b00, 6'd0));
    rst = 1'b0;
    pushEntry(1'b1, 1'b0, 8'h00, ev(S_INIT_V, 2'b00, 6'd0), "init");
    drainQueue();

    applyStimulus(8'h45, 1'b0, 0);
    applyStimulus(8'h0A, 1'b1, 3);
    applyStimulus(8'h9F, 1'b0, 0);
    applyStimulus(8'hC3, 1'b0, 0);
    applyStimulus(8'hC3, 1'b1, 0);
    applyStimulus(8'h9F, 1'b1, 0);
    drainQueue();

    // Asynchronous reset in the middle of STORE
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_in_store", actual, ev(S_INIT_V, 2'b00, 6'd0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("init_after_rst", actual, ev(S_INIT_V, 2'b00, 6'd0));
    curOp = 2'b00; curAdr = 6'd0;
    applyStimulus(8'h45, 1'b0, 0);
    pushEntry(1'b1, 1'b0, 8'h45, ev(S_FETCH_V, 2'b01, 6'd5), "fetch_end");
    drainQueue();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
